// File: rtl/reduce_pipe_if.sv
// reduce_pipe_if: operand/result valid-ready channels of the reduction pipeline
interface reduce_pipe_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_result;
  logic [1:0]       out_mode;
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_mode
  );
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_mode
  );
endinterface

// File: rtl/reduce_pipe.sv
// reduce_pipe: pipelined FANIN-ary AND/OR/XOR/NAND reduction tree with saturating hit counter
module reduce_pipe #(
  parameter int WIDTH = 32,
  parameter int FANIN = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  reduce_pipe_if.slave     io,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] hit_cnt
);
  function automatic int n_at(input int s);
    int n = WIDTH;
    for (int t = 0; t < s; t++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction
  function automatic int levels();
    int n = WIDTH;
    int s = 0;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      s++;
    end
    return s < 1 ? 1 : s;
  endfunction
  localparam int STAGES = levels();
  function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] v, input int n,
                                           input logic [1:0] m, input logic fin);
    logic [FANIN*WIDTH-1:0] ext;
    logic [WIDTH-1:0]       r;
    ext = {(FANIN*WIDTH){~(m[0] ^ m[1])}};
    for (int k = 0; k < WIDTH; k++) ext[k] = k < n ? v[k] : ext[k];
    for (int i = 0; i < WIDTH; i++)
      r[i] = m == 2'b10 ? ^ext[i*FANIN +: FANIN] :
             m == 2'b01 ? |ext[i*FANIN +: FANIN] : &ext[i*FANIN +: FANIN];
    r[0] = r[0] ^ (fin && m == 2'b11);
    return r;
  endfunction
  logic [STAGES-1:0] vld;
  logic [STAGES:0]   rdy;
  logic [CNT_W-1:0]  hit_q, hit_d;
  always_comb begin
    rdy[STAGES] = io.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) rdy[s] = !vld[s] || rdy[s+1];
  end
  for (genvar g = 0; g < STAGES; g++) begin : g_st
    localparam int NI = n_at(g);
    localparam int NO = n_at(g + 1);
    logic          v_q, v_d, sv;
    logic [1:0]    m_q, m_d, sm;
    logic [NI-1:0] sd;
    logic [NO-1:0] d_q, d_d;
    if (g == 0) begin : g_in
      assign sv = io.in_valid;
      assign sm = io.in_mode;
      assign sd = io.in_data;
    end else begin : g_mid
      assign sv = g_st[g-1].v_q;
      assign sm = g_st[g-1].m_q;
      assign sd = g_st[g-1].d_q;
    end
    always_comb begin
      v_d = rdy[g] ? sv : v_q;
      m_d = rdy[g] ? sm : m_q;
      d_d = rdy[g] ? NO'(lvl(WIDTH'(sd), NI, sm, g == STAGES - 1)) : d_q;
    end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        m_q <= 2'b00;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        m_q <= m_d;
        d_q <= d_d;
      end
    end
    assign vld[g] = v_q;
  end
  assign io.in_ready   = rdy[0];
  assign io.out_valid  = vld[STAGES-1];
  assign io.out_result = g_st[STAGES-1].d_q[0];
  assign io.out_mode   = g_st[STAGES-1].m_q;
  always_comb
    hit_d = cnt_clr ? '0 :
            (vld[STAGES-1] && io.out_ready && g_st[STAGES-1].d_q[0] && hit_q != '1) ? hit_q + 1'b1 : hit_q;
  always_ff @(posedge clk) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= hit_d;
  end
  assign hit_cnt = hit_q;
endmodule

// File: tb/tb_reduce_pipe.sv
// tb_reduce_pipe: table-driven and scoreboard-checked bench for reduce_pipe (WIDTH=8, FANIN=2)
module tb_reduce_pipe;
  typedef struct {
    logic [7:0] d;
    logic [1:0] m;
    logic       r;
  } vec_t;
  typedef struct {
    logic       r;
    logic [1:0] m;
    int         c;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        clr2 = 1'b0;
  logic [15:0] hit;
  logic [1:0]  hit2;
  int          npass = 0;
  int          ntot = 0;
  int          cyc = 0;
  int          hm = 0;
  bit          lat_chk = 1'b0;
  bit          or_rnd = 1'b0;
  exp_t        exp_q[$];
  reduce_pipe_if #(.WIDTH(8)) io ();
  reduce_pipe_if #(.WIDTH(8)) io2 ();
  reduce_pipe #(.WIDTH(8), .FANIN(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .io(io), .cnt_clr(cnt_clr), .hit_cnt(hit)
  );
  reduce_pipe #(.WIDTH(8), .FANIN(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .io(io2), .cnt_clr(clr2), .hit_cnt(hit2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic model(input logic [7:0] d, input logic [1:0] m);
    return m == 2'd0 ? &d : m == 2'd1 ? |d : m == 2'd2 ? ^d : ~&d;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    ntot++;
    if (a == e) npass++;
    else $display("FAIL %s: got %0d expected %0d", n, a, e);
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (!rst_n) hm = 0;
    else begin
      if (io.out_valid && io.out_ready) begin
        if (exp_q.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_out: got result %0d with empty scoreboard", io.out_result);
        end else begin
          x = exp_q.pop_front();
          chk("result", io.out_result, x.r);
          chk("mode", io.out_mode, x.m);
          if (lat_chk) chk("latency", cyc - x.c, 3);
          if (x.r && !cnt_clr) hm++;
        end
      end
      if (cnt_clr) hm = 0;
    end
  end
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic e);
    io.in_valid = 1'b1;
    io.in_data  = d;
    io.in_mode  = m;
    if (or_rnd) io.out_ready = $urandom_range(0, 1) == 1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (io.in_ready) begin
        exp_q.push_back('{r: e, m: m, c: cyc});
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (or_rnd) io.out_ready = $urandom_range(0, 1) == 1;
    end
    chk("send_timeout", 0, 1);
    io.in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic clear_cnt();
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr", hit, 0);
  endtask
  initial begin
    vec_t       tv[16];
    logic [7:0] bp[3];
    logic       bpr[3];
    logic [7:0] d;
    logic [1:0] m;
    int         acc, k2;
    logic       pend, bad, took;
    for (int i = 0; i < 9; i++) tv[i] = '{d: 8'((1 << i) - 1), m: 2'd0, r: i == 8};
    tv[9]  = '{d: 8'hFF, m: 2'd0, r: 1'b1};
    tv[10] = '{d: 8'h00, m: 2'd1, r: 1'b0};
    tv[11] = '{d: 8'h80, m: 2'd1, r: 1'b1};
    tv[12] = '{d: 8'h07, m: 2'd2, r: 1'b1};
    tv[13] = '{d: 8'h03, m: 2'd2, r: 1'b0};
    tv[14] = '{d: 8'hFF, m: 2'd3, r: 1'b0};
    tv[15] = '{d: 8'hFE, m: 2'd3, r: 1'b1};
    bp  = '{8'h01, 8'h03, 8'h07};
    bpr = '{1'b1, 1'b0, 1'b1};
    io.in_valid = 1'b0; io.in_data = '0; io.in_mode = '0; io.out_ready = 1'b0;
    io2.in_valid = 1'b0; io2.in_data = '0; io2.in_mode = '0; io2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_out_result", io.out_result, 0);
    chk("rst_out_mode", io.out_mode, 0);
    chk("rst_hit", hit, 0);
    chk("rst_in_ready", io.in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    io.out_ready = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < 9; i++) send(tv[i].d, tv[i].m, tv[i].r);
    drain();
    chk("walk_hit", hit, 1);
    clear_cnt();
    @(posedge clk);
    #1;
    for (int i = 9; i < 16; i++) send(tv[i].d, tv[i].m, tv[i].r);
    drain();
    chk("mixed_hit", hit, 4);
    lat_chk = 1'b0;
    clear_cnt();
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    io.in_valid = 1'b1;
    io.in_mode  = 2'd2;
    acc = 0;
    for (int t = 0; t < 5; t++) begin
      io.in_data = bp[acc > 2 ? 2 : acc];
      @(negedge clk);
      chk("bp_in_ready", io.in_ready, t < 3);
      took = io.in_ready;
      if (took) exp_q.push_back('{r: bpr[acc], m: 2'd2, c: cyc});
      if (t >= 3) begin
        chk("bp_hold_result", io.out_result, 1);
        chk("bp_hold_mode", io.out_mode, 2);
      end
      @(posedge clk);
      #1 acc += int'(took);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", io.in_ready, 1);
    drain();
    chk("bp_hit", hit, 2);
    io.in_valid = 1'b1;
    io.in_data  = 8'hFF;
    io.in_mode  = 2'd0;
    repeat (2) @(posedge clk);
    #1 io.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", io.out_valid, 0);
    chk("midrst_hit", hit, 0);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bad |= io.out_valid;
    end
    chk("midrst_no_stale", bad, 0);
    @(posedge clk);
    #1 io2.in_data = 8'hFF;
    io2.in_mode = 2'd0;
    k2 = 0;
    pend = 1'b0;
    for (int t = 0; t < 12; t++) begin
      io2.in_valid = t < 5;
      @(negedge clk);
      if (pend) chk("sat_cnt", hit2, k2 > 3 ? 3 : k2);
      pend = io2.out_valid;
      k2 += int'(pend);
      @(posedge clk);
      #1;
    end
    chk("sat_total", k2, 5);
    io2.in_valid = 1'b1;
    @(posedge clk);
    #1 io2.in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (io2.out_valid) break;
    end
    chk("sat_clr_wait", io2.out_valid, 1);
    clr2 = 1'b1;
    @(posedge clk);
    #1 clr2 = 1'b0;
    @(negedge clk);
    chk("sat_clr", hit2, 0);
    @(posedge clk);
    #1 or_rnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        io.in_valid = 1'b0;
        io.out_ready = $urandom_range(0, 1) == 1;
        @(posedge clk);
        #1;
      end
      d = 8'($urandom);
      m = 2'($urandom);
      send(d, m, model(d, m));
    end
    or_rnd = 1'b0;
    io.out_ready = 1'b1;
    drain();
    chk("rand_hit", hit, hm);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
endmodule
